qe_multi_decoder: RTL

Parametrised N-channel quadrature encoder decoder and the next generation of the single-channel QE block. Each channel has:
- input synchronisation and glitch filtering
- selectable x1/x2/x4 decode
- a modulo-counts-per-rev position counter with turns tracking
- index-driven zeroing
- pulse-period speed measurement
- illegal-transition detection
All channels share one word-addressed register port on the internal 32-bit bus side of the motion controller.

---
 rtl/qe_multi_decoder.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/qe_multi_decoder.sv
// -----------------------------------------------------------------------------
// qe_multi_decoder
// N-channel quadrature encoder decoder with a shared word-addressed register
// port. Each channel synchronises and glitch-filters its A/B/I pins, decodes
// x1/x2/x4 steps, and keeps a modulo-CPR position with a turns counter. It also
// clears COUNT on the index pulse, measures the step period, and flags illegal
// A/B transitions.
//
// Ports:
//   clk              system clock
//   reset            asynchronous active-low reset
//   qe_a/qe_b/qe_i   asynchronous encoder pins, one bit per channel
//   reg_addr         register word address
//   reg_wr/reg_rd    single-cycle write / read strobes
//   reg_wdata        write data
//   reg_rdata        read data. Registered; 0 when not valid.
//   reg_rdata_valid  one-cycle read acknowledge for mapped addresses
//   irq              registered OR of masked sticky status over all channels
//
// Per-channel register offsets: 0 COUNT, 1 TURNS, 2 PERIOD (RO), 3 CPR,
// 4 CONFIG, 5 STATUS (W1C), 6-7 reserved.
// -----------------------------------------------------------------------------
module qe_multi_decoder #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned FILTER_DEPTH = 3,
  parameter logic [31:0] PERIOD_MAX   = 32'h00FF_FFFF,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0040,
  parameter int unsigned ADDR_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] qe_a,
  input  logic [NUM_CHANNELS-1:0] qe_b,
  input  logic [NUM_CHANNELS-1:0] qe_i,
  input  logic [ADDR_WIDTH-1:0]   reg_addr,
  input  logic                    reg_wr,
  input  logic                    reg_rd,
  input  logic [31:0]             reg_wdata,
  output logic [31:0]             reg_rdata,
  output logic                    reg_rdata_valid,
  output logic                    irq
);

  localparam int unsigned FCW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam logic [FCW-1:0]         FILT_LAST = FCW'(FILTER_DEPTH - 1);
  localparam logic [FCW-1:0]         FILT_ONE  = FCW'(1);
  localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] PMAX      = PERIOD_MAX[COUNT_WIDTH-1:0];

  logic [31:0]             addr_ext;
  logic [NUM_CHANNELS-1:0] ch_hit;
  logic [NUM_CHANNELS-1:0] ch_irq;
  logic [31:0]             ch_rdata [NUM_CHANNELS];
  logic [31:0]             rd_mux;
  logic                    rd_hit;
  logic [COUNT_WIDTH-1:0]  wdata_cw;

  assign addr_ext = 32'(reg_addr);
  assign wdata_cw = reg_wdata[COUNT_WIDTH-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      localparam logic [31:0] CH_LO = BASE_ADDR + 32'(8 * gi);

      // Pin vectors are ordered {A, B, I}
      logic [2:0]             sync1_reg, sync2_reg, filt_reg, filt_prev_reg;
      logic [FCW-1:0]         filt_cnt_reg [3];
      logic [COUNT_WIDTH-1:0] count_reg, turns_reg, period_reg, cpr_reg, cyc_reg;
      logic [COUNT_WIDTH-1:0] count_next, turns_next;
      logic [8:0]             cfg_reg;
      logic [3:0]             status_reg, status_set, status_clr;
      logic                   dir_reg;

      logic [2:0]  sel;
      logic        wr_count, wr_turns, wr_cpr, wr_cfg, wr_status;
      logic        en, inv, idx_clr_en;
      logic [1:0]  mode;
      logic [1:0]  pos_prev, pos_cur;
      logic        a_chg, b_chg, legal, illegal, cw, qualify, count_ev, up;
      logic        idx_rise, idx_clr, wrap_ev, timeout_set;
      logic [31:0] rd_val;

      assign ch_hit[gi] = (addr_ext >= CH_LO) && (addr_ext < CH_LO + 32'd8);
      assign sel        = addr_ext[2:0] - BASE_ADDR[2:0];
      assign wr_count   = reg_wr && ch_hit[gi] && (sel == 3'd0);
      assign wr_turns   = reg_wr && ch_hit[gi] && (sel == 3'd1);
      assign wr_cpr     = reg_wr && ch_hit[gi] && (sel == 3'd3);
      assign wr_cfg     = reg_wr && ch_hit[gi] && (sel == 3'd4);
      assign wr_status  = reg_wr && ch_hit[gi] && (sel == 3'd5);

      assign en         = cfg_reg[0];
      assign mode       = cfg_reg[2:1];
      assign inv        = cfg_reg[3];
      assign idx_clr_en = cfg_reg[4];

      // Gray position of {A,B}: 00->0, 10->1, 11->2, 01->3, so CW is +1 mod 4
      assign pos_prev = {filt_prev_reg[1], filt_prev_reg[2] ^ filt_prev_reg[1]};
      assign pos_cur  = {filt_reg[1], filt_reg[2] ^ filt_reg[1]};
      assign a_chg    = filt_reg[2] ^ filt_prev_reg[2];
      assign b_chg    = filt_reg[1] ^ filt_prev_reg[1];
      assign legal    = a_chg ^ b_chg;
      assign illegal  = en && a_chg && b_chg;
      assign cw       = (pos_cur - pos_prev) == 2'd1;
      assign up       = cw ^ inv;
      assign idx_rise = filt_reg[0] && !filt_prev_reg[0];
      assign idx_clr  = idx_rise && idx_clr_en;

      always_comb begin
        qualify = legal;
        case (mode)
          2'b01:   qualify = legal && a_chg;
          2'b10:   qualify = legal && a_chg && filt_reg[2];
          default: qualify = legal;
        endcase
      end
      assign count_ev = en && qualify;

      // Position update; bus write beats index clear, which beats a step
      always_comb begin
        count_next = count_reg;
        turns_next = turns_reg;
        wrap_ev    = 1'b0;
        if (count_ev) begin
          if (up) begin
            // >= also pulls an out-of-range COUNT back after a CPR rewrite
            if ((cpr_reg != '0) && (count_reg >= cpr_reg - ONE)) begin
              count_next = '0;
              turns_next = turns_reg + ONE;
              wrap_ev    = 1'b1;
            end else begin
              count_next = count_reg + ONE;
            end
          end else begin
            if ((cpr_reg != '0) && (count_reg == '0)) begin
              count_next = cpr_reg - ONE;
              turns_next = turns_reg - ONE;
              wrap_ev    = 1'b1;
            end else begin
              count_next = count_reg - ONE;
            end
          end
        end
        if (idx_clr) begin
          count_next = '0;
          turns_next = turns_reg;
          wrap_ev    = 1'b0;
        end
        if (wr_count) begin
          count_next = wdata_cw;
          turns_next = turns_reg;
          wrap_ev    = 1'b0;
        end
        if (wr_turns) begin
          turns_next = wdata_cw;
        end
      end

      // Timeout fires once, on the cycle the idle counter lands on the clamp
      assign timeout_set = en && !count_ev && (cyc_reg != PMAX) && (cyc_reg + ONE == PMAX);
      assign status_set  = {wrap_ev, timeout_set, illegal, idx_rise};
      assign status_clr  = wr_status ? reg_wdata[3:0] : 4'b0000;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_reg     <= '0;
          sync2_reg     <= '0;
          filt_reg      <= '0;
          filt_prev_reg <= '0;
          for (int k = 0; k < 3; k++) filt_cnt_reg[k] <= '0;
          count_reg     <= '0;
          turns_reg     <= '0;
          period_reg    <= '0;
          cpr_reg       <= '0;
          cyc_reg       <= '0;
          cfg_reg       <= '0;
          status_reg    <= '0;
          dir_reg       <= 1'b0;
        end else begin
          sync1_reg     <= {qe_a[gi], qe_b[gi], qe_i[gi]};
          sync2_reg     <= sync1_reg;
          filt_prev_reg <= filt_reg;
          // A filtered bit flips on the FILTER_DEPTH-th consecutive differing sample
          for (int k = 0; k < 3; k++) begin
            if (sync2_reg[k] == filt_reg[k]) begin
              filt_cnt_reg[k] <= '0;
            end else if (filt_cnt_reg[k] == FILT_LAST) begin
              filt_reg[k]     <= sync2_reg[k];
              filt_cnt_reg[k] <= '0;
            end else begin
              filt_cnt_reg[k] <= filt_cnt_reg[k] + FILT_ONE;
            end
          end

          count_reg  <= count_next;
          turns_reg  <= turns_next;
          status_reg <= (status_reg & ~status_clr) | status_set;
          if (wr_cpr) cpr_reg <= wdata_cw;
          if (wr_cfg) cfg_reg <= reg_wdata[8:0];
          if (en && legal) dir_reg <= cw;

          if (!en) begin
            cyc_reg <= '0;
          end else if (count_ev) begin
            period_reg <= (cyc_reg >= PMAX) ? PMAX : cyc_reg + ONE;
            cyc_reg    <= '0;
          end else if (cyc_reg != PMAX) begin
            cyc_reg <= cyc_reg + ONE;
            if (timeout_set) period_reg <= PMAX;
          end
        end
      end

      always_comb begin
        rd_val = '0;
        case (sel)
          3'd0:    rd_val = 32'(count_reg);
          3'd1:    rd_val = 32'(turns_reg);
          3'd2:    rd_val = 32'(period_reg);
          3'd3:    rd_val = 32'(cpr_reg);
          3'd4:    rd_val = {23'd0, cfg_reg};
          3'd5:    rd_val = {27'd0, dir_reg, status_reg};
          default: rd_val = '0;
        endcase
      end

      assign ch_rdata[gi] = rd_val;
      assign ch_irq[gi]   = |(status_reg & cfg_reg[8:5]);
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_hit[c]) rd_mux = rd_mux | ch_rdata[c];
    end
  end

  assign rd_hit = reg_rd && (|ch_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_rdata       <= '0;
      reg_rdata_valid <= 1'b0;
      irq             <= 1'b0;
    end else begin
      reg_rdata_valid <= rd_hit;
      reg_rdata       <= rd_hit ? rd_mux : 32'd0;
      irq             <= |ch_irq;
    end
  end

endmodule
